if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
- IF stage upstream of the branch predictor. Holds the fetch PC, drives it to the predictor as the current PC, and selects the next PC from the predictor's 2-bit select and the redirect targets.
- Issues instruction-memory requests over a valid/ready handshake and tracks up to MAX_OUTSTANDING in-flight fetches.
- Drops stale responses after a flush using an epoch bit.
- Loads the IF/ID register (instr, pc, pc+4, prediction flag) consumed by decode and the predictor.

Parameters:
RESET_PC, 32'h0000_0000, PC fetched first after reset
MAX_OUTSTANDING, 2, max in-flight imem requests (power of 2, ≥1)
NOP_INSTR, 32'h0000_0013, instruction injected into ID on bubble/flush

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_stall  in  1  hazard stall; hold IF/ID and PC
i_flush  in  1  mispredict flush from EX
i_pc_sel  in  2  00 pc+4, 01 EX ALU target, 10 EX pc+4, 11 predicted target
i_pred_target  in  32  predicted target for o_pc_now
i_alu_ex  in  32  redirect target (taken/jump)
i_pc_four_EX  in  32  redirect target (not-taken fall-through)
o_pc_now  out  32  current fetch PC (to predictor)
o_imem_req_valid  out  1  fetch request valid
i_imem_req_ready  in  1  imem accepts request
o_imem_addr  out  32  request address (= o_pc_now)
i_imem_rsp_valid  in  1  response valid (in order, ≥1 cycle after accept)
i_imem_rsp_data  in  32  fetched instruction
o_instr_ID  out  32  IF/ID instruction
o_pc_debug_ID  out  32  IF/ID PC
o_pc_four_ID  out  32  IF/ID PC+4
o_pc_sel_ID  out  1  IF/ID: fetched under predicted-taken (sel==11)
o_valid_ID  out  1  IF/ID entry valid

Behaviour:
- Clock and reset: single clock i_clk. Reset is asynchronous, active-low (i_rst_n). On reset:
  - pc=RESET_PC, epoch=0, outstanding=0, metadata FIFO empty.
  - o_valid_ID=0, o_instr_ID=NOP_INSTR, o_pc_debug_ID=0, o_pc_four_ID=0, o_pc_sel_ID=0, o_imem_req_valid=0.
- Request issue:
  - o_imem_req_valid=1 when not in reset, outstanding<MAX_OUTSTANDING, !i_stall, !i_flush.
  - Accept = req_valid & req_ready.
  - On accept, push {pc, pc+4, pc_sel==11, epoch} into the metadata FIFO and update pc: 00→pc+4, 11→i_pred_target, 01/10 without flush→pc+4.
  - All PC arithmetic is mod 2^32; 32'hFFFF_FFFC+4 wraps to 0.
- Flush (highest priority, overrides stall):
  - Same cycle: req_valid=0.
  - Next cycle: pc = i_alu_ex if i_pc_sel==01, else i_pc_four_EX; epoch toggles; IF/ID loads a bubble (o_valid_ID=0, instr=NOP_INSTR, o_pc_sel_ID=0).
  - Outstanding count and FIFO are retained so late responses are still counted and popped.
- Response handling:
  - On i_imem_rsp_valid, pop the FIFO head.
  - Head epoch ≠ current epoch → discard silently; counter decrements.
  - Epoch matches and !i_stall → IF/ID loads {rsp_data, head.pc, head.pc4, head.pred}, o_valid_ID=1.
  - Matching response while i_stall → hold in a 1-entry skid register. Issue is already blocked by stall. The skid drains to IF/ID the first cycle stall drops, then normal responses resume.
  - A flush clears the skid.
- No response and !i_stall → IF/ID loads a bubble. i_stall → IF/ID holds.
- outstanding += accept, −= rsp_valid, same cycle.
- Protocol errors:
  - Response with an empty FIFO is a protocol error: assertion fires, response ignored.
  - FIFO overflow must be unreachable.
- Reset mid-operation: everything returns to reset values. Responses after reset with an empty FIFO are ignored.
- FSM states:
  - RUN: issuing.
  - FULL: outstanding==MAX_OUTSTANDING, no issue.
  - HOLD: stall with skid occupied.
  - Transitions follow the counter and stall conditions; state is visible only through o_imem_req_valid.

Decomposition:
- Shared package (if_pkg): pc_sel encodings (PC_SEL_SEQ=2'b00, PC_SEL_ALU=2'b01, PC_SEL_FALL=2'b10, PC_SEL_PRED=2'b11), NOP_INSTR, and the fetch_meta_t struct {pc, pc4, pred, epoch}.
- One sub-module: fetch_meta_fifo. Parameterised synchronous FIFO with depth MAX_OUTSTANDING and full/empty flags.

Test Plan:
- Reset release, imem ready with 1-cycle latency, sel=00 → addrs 0,4,8,C on consecutive cycles; o_pc_debug_ID 0,4,8 with o_valid_ID=1 one cycle after each response.
- pc=0x40, sel=11, pred_target=0x100 → next addr 0x100; the ID entry for 0x40 has o_pc_sel_ID=1.
- Flush with sel=01, alu_ex=0x200 while 2 fetches are outstanding → both responses discarded (no o_valid_ID), next addr 0x200, epoch flips.
- i_imem_req_ready=0 for 3 cycles → req_valid held, addr stable, no PC advance. With 2 accepted and no responses → req_valid=0 until a response arrives.
- i_stall asserted while a response arrives (instr 0xDEADBEEF) → IF/ID holds. On stall release, IF/ID shows 0xDEADBEEF next cycle with the correct pc.
- pc=0xFFFF_FFFC, sel=00 → next addr 0x0000_0000; o_pc_four_ID=0.

Source files
------------

// File: rtl/if_pkg.sv
// Shared types and encodings for the instruction-fetch stage.
package if_pkg;

  localparam logic [1:0] PC_SEL_SEQ  = 2'b00;
  localparam logic [1:0] PC_SEL_ALU  = 2'b01;
  localparam logic [1:0] PC_SEL_FALL = 2'b10;
  localparam logic [1:0] PC_SEL_PRED = 2'b11;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        pred;
    logic        epoch;
  } fetch_meta_t;

endpackage

// File: rtl/fetch_meta_fifo.sv
// In-order metadata FIFO pairing each accepted fetch with its eventual response.
module fetch_meta_fifo
  import if_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  fetch_meta_t wdata,
  input  logic        pop,
  output fetch_meta_t rdata,
  output logic        full,
  output logic        empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  fetch_meta_t   mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;
  logic          push_ok, pop_ok;

  // Explicit wrap keeps DEPTH == 1 correct with a 1-bit pointer.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = mem_q[rptr_q];

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wptr_q <= ptr_inc(wptr_q);
      if (pop_ok)  rptr_q <= ptr_inc(rptr_q);
      count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// IF stage: owns the fetch PC, issues imem requests, filters stale responses by epoch
// and loads the IF/ID register.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] NOP_INSTR       = if_pkg::NOP_INSTR
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic [1:0]  i_pc_sel,
  input  logic [31:0] i_pred_target,
  input  logic [31:0] i_alu_ex,
  input  logic [31:0] i_pc_four_EX,
  output logic [31:0] o_pc_now,
  output logic        o_imem_req_valid,
  input  logic        i_imem_req_ready,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_rsp_valid,
  input  logic [31:0] i_imem_rsp_data,
  output logic [31:0] o_instr_ID,
  output logic [31:0] o_pc_debug_ID,
  output logic [31:0] o_pc_four_ID,
  output logic        o_pc_sel_ID,
  output logic        o_valid_ID
);

  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {StRun, StFull, StHold} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, pc_plus4;
  logic        epoch_q;
  logic [CW-1:0] cnt_q, cnt_d;

  logic        skid_valid_q, skid_valid_d;
  fetch_meta_t skid_meta_q, skid_meta_d;
  logic [31:0] skid_instr_q, skid_instr_d;

  logic [31:0] instr_id_q, instr_id_d, pc_id_q, pc_id_d, pc4_id_q, pc4_id_d;
  logic        pred_id_q, pred_id_d, valid_id_q, valid_id_d;

  logic        req_en, accept, rsp_pop, rsp_live, fifo_full, fifo_empty;
  fetch_meta_t push_meta, head;

  assign pc_plus4  = pc_q + 32'd4;
  assign accept    = o_imem_req_valid & i_imem_req_ready;
  assign rsp_pop   = i_imem_rsp_valid & ~fifo_empty;
  assign rsp_live  = rsp_pop & (head.epoch == epoch_q);
  assign push_meta = '{pc: pc_q, pc4: pc_plus4, pred: (i_pc_sel == PC_SEL_PRED), epoch: epoch_q};
  assign cnt_d     = cnt_q + CW'(accept) - CW'(rsp_pop);

  fetch_meta_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_meta_fifo (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .push  (accept),
    .wdata (push_meta),
    .pop   (rsp_pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d = StRun;
    if (cnt_d == CW'(MAX_OUTSTANDING)) state_d = StFull;
    else if (skid_valid_d)             state_d = StHold;
    unique case (state_q)
      StRun, StHold: req_en = 1'b1;
      StFull:        req_en = 1'b0;
      default:       req_en = 1'b0;
    endcase
    o_imem_req_valid = i_rst_n & req_en & ~i_stall & ~i_flush;
  end

  always_comb begin
    pc_d = pc_q;
    if (i_flush)     pc_d = (i_pc_sel == PC_SEL_ALU) ? i_alu_ex : i_pc_four_EX;
    else if (accept) pc_d = (i_pc_sel == PC_SEL_PRED) ? i_pred_target : pc_plus4;
  end

  // A matching response during stall parks in the skid; while it drains, a new one refills it.
  always_comb begin
    skid_valid_d = skid_valid_q;
    skid_meta_d  = skid_meta_q;
    skid_instr_d = skid_instr_q;
    if (i_flush) begin
      skid_valid_d = 1'b0;
    end else if (i_stall || skid_valid_q) begin
      if (!i_stall) skid_valid_d = 1'b0;
      if (rsp_live) begin
        skid_valid_d = 1'b1;
        skid_meta_d  = head;
        skid_instr_d = i_imem_rsp_data;
      end
    end
  end

  always_comb begin
    instr_id_d = instr_id_q;
    pc_id_d    = pc_id_q;
    pc4_id_d   = pc4_id_q;
    pred_id_d  = pred_id_q;
    valid_id_d = valid_id_q;
    if (i_flush || !i_stall) begin
      instr_id_d = NOP_INSTR;
      pc_id_d    = '0;
      pc4_id_d   = '0;
      pred_id_d  = 1'b0;
      valid_id_d = 1'b0;
      if (!i_flush && skid_valid_q) begin
        instr_id_d = skid_instr_q;
        pc_id_d    = skid_meta_q.pc;
        pc4_id_d   = skid_meta_q.pc4;
        pred_id_d  = skid_meta_q.pred;
        valid_id_d = 1'b1;
      end else if (!i_flush && rsp_live) begin
        instr_id_d = i_imem_rsp_data;
        pc_id_d    = head.pc;
        pc4_id_d   = head.pc4;
        pred_id_d  = head.pred;
        valid_id_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= StRun;
      pc_q         <= RESET_PC;
      epoch_q      <= 1'b0;
      cnt_q        <= '0;
      skid_valid_q <= 1'b0;
      skid_meta_q  <= '0;
      skid_instr_q <= '0;
      instr_id_q   <= NOP_INSTR;
      pc_id_q      <= '0;
      pc4_id_q     <= '0;
      pred_id_q    <= 1'b0;
      valid_id_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      epoch_q      <= epoch_q ^ i_flush;
      cnt_q        <= cnt_d;
      skid_valid_q <= skid_valid_d;
      skid_meta_q  <= skid_meta_d;
      skid_instr_q <= skid_instr_d;
      instr_id_q   <= instr_id_d;
      pc_id_q      <= pc_id_d;
      pc4_id_q     <= pc4_id_d;
      pred_id_q    <= pred_id_d;
      valid_id_q   <= valid_id_d;
    end
  end

  assign o_pc_now      = pc_q;
  assign o_imem_addr   = pc_q;
  assign o_instr_ID    = instr_id_q;
  assign o_pc_debug_ID = pc_id_q;
  assign o_pc_four_ID  = pc4_id_q;
  assign o_pc_sel_ID   = pred_id_q;
  assign o_valid_ID    = valid_id_q;

  a_rsp_has_meta: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    i_imem_rsp_valid |-> !fifo_empty);
  a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    accept |-> !fifo_full);
  a_skid_single: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (i_stall && !i_flush && skid_valid_q) |-> !rsp_live);

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: in-order memory model with a scoreboard of expected IF/ID entries.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall, flush, req_ready, rsp_valid;
  logic [1:0]  pc_sel;
  logic [31:0] pred_target, alu_ex, pc_four_ex, rsp_data;
  logic [31:0] pc_now, imem_addr, instr_id, pc_id, pc4_id;
  logic        req_valid, pred_id, valid_id;

  always #5 clk = ~clk;

  if_fetch_unit dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_stall          (stall),
    .i_flush          (flush),
    .i_pc_sel         (pc_sel),
    .i_pred_target    (pred_target),
    .i_alu_ex         (alu_ex),
    .i_pc_four_EX     (pc_four_ex),
    .o_pc_now         (pc_now),
    .o_imem_req_valid (req_valid),
    .i_imem_req_ready (req_ready),
    .o_imem_addr      (imem_addr),
    .i_imem_rsp_valid (rsp_valid),
    .i_imem_rsp_data  (rsp_data),
    .o_instr_ID       (instr_id),
    .o_pc_debug_ID    (pc_id),
    .o_pc_four_ID     (pc4_id),
    .o_pc_sel_ID      (pred_id),
    .o_valid_ID       (valid_id)
  );

  typedef struct {
    logic [31:0] addr;
    logic        pred;
    logic        epoch;
    int          ready_at;
  } pend_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        pred;
    int          due;   // 0: timing not checked (stalled)
  } exp_t;

  typedef struct {
    logic [31:0] start_pc;
    logic [1:0]  sel;
    logic [31:0] pred;
    logic [31:0] exp_addr;
  } vec_t;

  pend_t pend_q[$];
  exp_t  exp_q[$];
  int    errors = 0;
  int    checks = 0;
  int    cycle = 0;
  logic  mem_auto = 1'b0;
  logic  tb_epoch = 1'b0;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (a == 32'h0000_0800) return 32'hDEAD_BEEF;
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b, want %b", name, act, req);
    end
  endtask

  // One clock: memory response, accept capture, edge, then scoreboard compare at negedge.
  task automatic step();
    pend_t p;
    exp_t  e;
    rsp_valid = 1'b0;
    rsp_data  = '0;
    if (mem_auto && !flush && rst_n && pend_q.size() > 0 && pend_q[0].ready_at <= cycle) begin
      p = pend_q.pop_front();
      rsp_valid = 1'b1;
      rsp_data  = mem_data(p.addr);
      if (p.epoch == tb_epoch) begin
        e.instr = mem_data(p.addr);
        e.pc    = p.addr;
        e.pc4   = p.addr + 32'd4;
        e.pred  = p.pred;
        e.due   = stall ? 0 : cycle + 1;
        exp_q.push_back(e);
      end
    end
    #1;
    if (req_valid && req_ready) begin
      p.addr     = imem_addr;
      p.pred     = (pc_sel == 2'b11);
      p.epoch    = tb_epoch;
      p.ready_at = cycle + 1;
      pend_q.push_back(p);
    end
    if (flush) tb_epoch = ~tb_epoch;
    @(posedge clk);
    @(negedge clk);
    cycle++;
    rsp_valid = 1'b0;
    if (valid_id) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL id_unexpected: got valid entry pc=%h instr=%h, want no entry", pc_id,
                 instr_id);
      end else begin
        e = exp_q.pop_front();
        if (instr_id !== e.instr || pc_id !== e.pc || pc4_id !== e.pc4 || pred_id !== e.pred ||
            (e.due != 0 && cycle != e.due)) begin
          errors++;
          $display("FAIL id_entry: got instr=%h pc=%h pc4=%h pred=%b cyc=%0d, want %h %h %h %b %0d",
                   instr_id, pc_id, pc4_id, pred_id, cycle, e.instr, e.pc, e.pc4, e.pred, e.due);
        end
      end
    end else if (exp_q.size() > 0 && exp_q[0].due != 0 && exp_q[0].due <= cycle) begin
      checks++;
      errors++;
      $display("FAIL id_missing: got no valid entry, want pc=%h", exp_q[0].pc);
      void'(exp_q.pop_front());
    end
  endtask

  task automatic drain();
    int n = 0;
    req_ready = 1'b0;
    mem_auto  = 1'b1;
    while ((pend_q.size() > 0 || exp_q.size() > 0) && n < 30) begin
      step();
      n++;
    end
    check("drain_pending", 32'(pend_q.size() + exp_q.size()), 32'd0);
    step();
  endtask

  task automatic redirect(input logic [31:0] target);
    flush      = 1'b1;
    pc_sel     = 2'b10;
    pc_four_ex = target;
    req_ready  = 1'b0;
    step();
    flush  = 1'b0;
    pc_sel = 2'b00;
  endtask

  vec_t vecs[6];

  initial begin
    stall = 0; flush = 0; req_ready = 0; rsp_valid = 0; rsp_data = '0;
    pc_sel = 2'b00; pred_target = '0; alu_ex = '0; pc_four_ex = '0;

    vecs[0] = '{32'h0000_0040, 2'b11, 32'h0000_0100, 32'h0000_0100};
    vecs[1] = '{32'h0000_1000, 2'b00, 32'hDEAD_0000, 32'h0000_1004};
    vecs[2] = '{32'hFFFF_FFFC, 2'b00, 32'h0000_0000, 32'h0000_0000};
    vecs[3] = '{32'h0000_0080, 2'b01, 32'h0000_0300, 32'h0000_0084};
    vecs[4] = '{32'h0000_0090, 2'b10, 32'h0000_0300, 32'h0000_0094};
    vecs[5] = '{32'hFFFF_FFFC, 2'b11, 32'h0000_0020, 32'h0000_0020};

    repeat (2) @(negedge clk);
    check1("rst_valid_id", valid_id, 1'b0);
    check("rst_instr_id", instr_id, 32'h0000_0013);
    check("rst_pc_id", pc_id, 32'h0);
    check("rst_pc4_id", pc4_id, 32'h0);
    check1("rst_pred_id", pred_id, 1'b0);
    check1("rst_req_valid", req_valid, 1'b0);
    check("rst_pc_now", pc_now, 32'h0);

    // Sequential fetch from reset.
    rst_n = 1'b1; req_ready = 1'b1; mem_auto = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check1($sformatf("seq%0d_req_valid", i), req_valid, 1'b1);
      check($sformatf("seq%0d_addr", i), imem_addr, 32'(i * 4));
      step();
    end
    drain();

    // Next-PC selection and wrap.
    foreach (vecs[i]) begin
      redirect(vecs[i].start_pc);
      pc_sel = vecs[i].sel; pred_target = vecs[i].pred; req_ready = 1'b1;
      #1;
      check($sformatf("vec%0d_addr", i), imem_addr, vecs[i].start_pc);
      step();
      req_ready = 1'b0; pc_sel = 2'b00;
      #1;
      check($sformatf("vec%0d_next", i), imem_addr, vecs[i].exp_addr);
      drain();
    end

    // Flush with two fetches in flight: both responses must be dropped.
    redirect(32'h0000_0500);
    mem_auto = 1'b0; req_ready = 1'b1;
    step(); step();
    #1;
    check1("full_req_valid", req_valid, 1'b0);
    step();
    flush = 1'b1; pc_sel = 2'b01; alu_ex = 32'h0000_0200; pc_four_ex = 32'h0000_0999;
    #1;
    check1("flush_req_valid", req_valid, 1'b0);
    step();
    flush = 1'b0; pc_sel = 2'b00;
    #1;
    check("flush_addr", imem_addr, 32'h0000_0200);
    check1("flush_still_full", req_valid, 1'b0);
    mem_auto = 1'b1;
    repeat (4) step();
    drain();

    // Backpressure on the request channel.
    redirect(32'h0000_0700);
    for (int i = 0; i < 3; i++) begin
      #1;
      check1($sformatf("bp%0d_req_valid", i), req_valid, 1'b1);
      check($sformatf("bp%0d_addr", i), imem_addr, 32'h0000_0700);
      step();
    end
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    #1;
    check("bp_next_addr", imem_addr, 32'h0000_0704);
    drain();

    // Response during stall goes through the skid.
    redirect(32'h0000_0800);
    mem_auto = 1'b0; req_ready = 1'b1;
    step();
    req_ready = 1'b0; stall = 1'b1; mem_auto = 1'b1;
    #1;
    check1("stall_req_valid", req_valid, 1'b0);
    step();
    check1("stall_hold0", valid_id, 1'b0);
    step();
    check1("stall_hold1", valid_id, 1'b0);
    stall = 1'b0;
    step();
    check1("stall_rel_valid", valid_id, 1'b1);
    check("stall_rel_instr", instr_id, 32'hDEAD_BEEF);
    check("stall_rel_pc", pc_id, 32'h0000_0800);
    drain();

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "timeout");
  end

endmodule
